led_blink_sequencer: RTL and testbench
======================================

// Module: led_blink_sequencer
// PURPOSE
//   Consumer end of the tick_enable interface from enable_generator.
//   Counts tick_enable pulses and drives an LED in bursts: BURST_LEN blinks
//   (ON_TICKS lit, OFF_TICKS dark), then a PAUSE_TICKS gap, then repeat.
//   Started and stopped by one-cycle pulses. Sits between enable_generator and the board LED pin.
// PARAMETERS
//   ON_TICKS     2   ticks LED is lit per blink (>=1)
//   OFF_TICKS    3   ticks LED is dark per blink (>=1)
//   BURST_LEN    3   blinks per burst (>=1)
//   PAUSE_TICKS  10  dark ticks between bursts in repeat mode (>=0)
//   CNT_W        8   width of blink_cnt
// PORTS
//   sys_clk      in   1      system clock, all logic on rising edge
//   sys_rst      in   1      synchronous reset, active-high
//   tick_enable  in   1      one-cycle tick pulse from enable_generator
//   start        in   1      one-cycle pulse: begin sequence from IDLE
//   stop         in   1      one-cycle pulse: abort to IDLE
//   mode         in   1      0 = repeat bursts forever, 1 = single burst; sampled on start
//   led          out  1      LED drive, 1 = lit
//   busy         out  1      1 whenever state != IDLE
//   burst_done   out  1      one-cycle pulse when a burst's last OFF phase ends
//   blink_cnt    out  CNT_W  completed blinks since reset, saturating
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, led=0, busy=0, burst_done=0, blink_cnt=0,
//     internal tick counter, blink index and latched mode cleared.
//   - Reset and operation:
//     - sys_rst is sampled on sys_clk only and overrides everything, including mid-burst.
//   - FSM states IDLE, ON, OFF, PAUSE. led=1 iff state==ON.
//     - busy=1 iff state!=IDLE. Both update the cycle after the transition edge.
//   - IDLE:
//     - start=1 and stop=0 -> ON; tick_cnt=0, blink_idx=0, mode latched.
//     - tick_enable in IDLE is ignored.
//     - A tick in the same cycle as start is ignored; counting begins the next cycle.
//   - ON:
//     - Each tick_enable increments tick_cnt.
//     - The tick that makes the count reach ON_TICKS -> OFF, tick_cnt=0.
//   - OFF:
//     - The tick reaching OFF_TICKS completes a blink: blink_cnt+1, saturating at 2^CNT_W-1, tick_cnt=0.
//     - If blink_idx < BURST_LEN-1: blink_idx+1, go to ON.
//     - Otherwise burst_done=1 for one cycle and blink_idx=0.
//       - mode=1 -> IDLE.
//       - mode=0 and PAUSE_TICKS>0 -> PAUSE.
//       - mode=0 and PAUSE_TICKS=0 -> ON.
//   - PAUSE:
//     - The tick reaching PAUSE_TICKS -> ON, tick_cnt=0.
//   - stop=1 in any state -> IDLE next cycle; led=0, counters cleared, no burst_done.
//     - blink_cnt is not cleared by stop.
//   - Simultaneous inputs:
//     - start and stop together: stop wins.
//     - start while busy: ignored; does not restart the sequence or relatch mode.
//   - Phase length is counted in received ticks, so the first ON phase may be up to one
//     tick period shorter, depending on start phase. No clock-count assumptions.
//   - tick_enable held high for consecutive cycles counts one tick per cycle.
//   - Bad parameters: ON_TICKS, OFF_TICKS or BURST_LEN = 0 is a fatal elaboration error
//     (generate-time check).
// TESTING  (defaults; bench ticks every 10 clocks, i.e. 100Hz clock / 10Hz tick)
//   1. Reset, then start with mode=1.
//      -> led high for exactly 2 ticks and low for 3 ticks, 3 times.
//      -> burst_done pulses once on the 15th tick; busy falls; blink_cnt=3.
//   2. mode=0, run 40 ticks.
//      -> pattern repeats with a 10-tick dark pause.
//      -> burst_done at ticks 15 and 40; blink_cnt=6.
//   3. Assert stop during the 2nd ON phase.
//      -> led=0 and busy=0 next cycle; no burst_done; blink_cnt=1.
//      -> a later start restarts at blink 0.
//   4. start and stop in the same cycle -> stays IDLE, busy=0.
//      start pulse mid-burst -> sequence unaffected.
//   5. tick_enable with start in the same cycle -> not counted; first ON phase still needs 2 later ticks.
//      No ticks for 1000 cycles -> state and led frozen.
//   6. sys_rst asserted mid-OFF phase -> all outputs 0 next cycle, including blink_cnt.
//      CNT_W=2 with 5 blinks -> blink_cnt saturates at 3.

Source files
------------

// File: rtl/led_blink_sequencer_if.sv
// Bundles the tick input, control pulses and LED/status outputs of led_blink_sequencer.
`default_nettype none

interface led_blink_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             tick_enable;
  logic             start;
  logic             stop;
  logic             mode;
  logic             led;
  logic             busy;
  logic             burst_done;
  logic [CNT_W-1:0] blink_cnt;

  modport master (
    output tick_enable, start, stop, mode,
    input  led, busy, burst_done, blink_cnt
  );

  modport slave (
    input  tick_enable, start, stop, mode,
    output led, busy, burst_done, blink_cnt
  );
endinterface

`default_nettype wire

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: counts tick_enable pulses and drives an LED in bursts of blinks
// separated by a pause, with single-burst or repeat mode.
`default_nettype none

module led_blink_sequencer #(
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 3,
  parameter int BURST_LEN   = 3,
  parameter int PAUSE_TICKS = 10,
  parameter int CNT_W       = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  led_blink_sequencer_if.slave  bus
);

  generate
    if (ON_TICKS < 1 || OFF_TICKS < 1 || BURST_LEN < 1) begin : g_bad_params
      $fatal(1, "led_blink_sequencer: ON_TICKS, OFF_TICKS and BURST_LEN must be >= 1");
    end
  endgenerate

  localparam int MAX_T_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T   = (MAX_T_A > PAUSE_TICKS) ? MAX_T_A : PAUSE_TICKS;
  localparam int TCW     = $clog2(MAX_T + 1);
  localparam int IW      = $clog2(BURST_LEN + 1);

  // Terminal values are "count before the final tick", so a phase ends on the tick reaching N.
  localparam logic [TCW-1:0]   c_ON_LAST    = TCW'(ON_TICKS - 1);
  localparam logic [TCW-1:0]   c_OFF_LAST   = TCW'(OFF_TICKS - 1);
  localparam logic [TCW-1:0]   c_PAUSE_LAST = TCW'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);
  localparam logic [IW-1:0]    c_IDX_LAST   = IW'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TCW-1:0]   tick_q, tick_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (bus.stop) begin
      state_d = S_IDLE;
      tick_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_ON;
            tick_d  = '0;
            idx_d   = '0;
            mode_d  = bus.mode;
          end
        end
        S_ON: begin
          if (bus.tick_enable) begin
            if (tick_q == c_ON_LAST) begin
              state_d = S_OFF;
              tick_d  = '0;
            end else begin
              tick_d = tick_q + TCW'(1);
            end
          end
        end
        S_OFF: begin
          if (bus.tick_enable) begin
            if (tick_q == c_OFF_LAST) begin
              tick_d = '0;
              if (cnt_q != c_CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
              if (idx_q != c_IDX_LAST) begin
                idx_d   = idx_q + IW'(1);
                state_d = S_ON;
              end else begin
                idx_d  = '0;
                done_d = 1'b1;
                if (mode_q) begin
                  state_d = S_IDLE;
                end else if (PAUSE_TICKS > 0) begin
                  state_d = S_PAUSE;
                end else begin
                  state_d = S_ON;
                end
              end
            end else begin
              tick_d = tick_q + TCW'(1);
            end
          end
        end
        S_PAUSE: begin
          if (bus.tick_enable) begin
            if (tick_q == c_PAUSE_LAST) begin
              state_d = S_ON;
              tick_d  = '0;
            end else begin
              tick_d = tick_q + TCW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
          idx_d   = '0;
        end
      endcase
    end

    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.busy       = busy_q;
  assign bus.burst_done = done_q;
  assign bus.blink_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_sequencer.sv
// Scoreboard bench for led_blink_sequencer: a tick-count reference model queues expected
// outputs per cycle and burst_done events; a monitor pops and compares.
`default_nettype none

module tb_led_blink_sequencer;

  localparam int ON     = 2;
  localparam int OFF    = 3;
  localparam int BL     = 3;
  localparam int PAUSE  = 10;
  localparam int CW     = 8;
  localparam int CW_SAT = 2;
  localparam int BLINK  = ON + OFF;
  localparam int BLW    = BL * BLINK;
  localparam int PER    = BLW + PAUSE;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int CMAX_S = (1 << CW_SAT) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_tick = 1'b0, d_start = 1'b0, d_stop = 1'b0, d_mode = 1'b0;

  led_blink_sequencer_if #(.CNT_W(CW))     bus_a ();
  led_blink_sequencer_if #(.CNT_W(CW_SAT)) bus_b ();

  assign bus_a.tick_enable = d_tick;
  assign bus_a.start       = d_start;
  assign bus_a.stop        = d_stop;
  assign bus_a.mode        = d_mode;
  assign bus_b.tick_enable = d_tick;
  assign bus_b.start       = d_start;
  assign bus_b.stop        = d_stop;
  assign bus_b.mode        = d_mode;

  led_blink_sequencer #(
    .ON_TICKS(ON), .OFF_TICKS(OFF), .BURST_LEN(BL), .PAUSE_TICKS(PAUSE), .CNT_W(CW)
  ) u_dut (
    .sys_clk(clk), .sys_rst(rst), .bus(bus_a)
  );

  led_blink_sequencer #(
    .ON_TICKS(ON), .OFF_TICKS(OFF), .BURST_LEN(BL), .PAUSE_TICKS(PAUSE), .CNT_W(CW_SAT)
  ) u_dut_sat (
    .sys_clk(clk), .sys_rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int led;
    int busy;
    int done;
    int cnt;
    int cnt_sat;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   drv_cyc = 0;
  int   tick_phase = 0;

  // Reference model: a run is described only by how many ticks it has counted.
  bit m_run  = 1'b0;
  int m_t    = 0;
  bit m_mode = 1'b0;
  int m_total = 0;

  function automatic int blinks_at(int t);
    int rem = (t % PER) / BLINK;
    return (t / PER) * BL + ((rem < BL) ? rem : BL);
  endfunction

  function automatic int bursts_at(int t);
    return (t / PER) + (((t % PER) >= BLW) ? 1 : 0);
  endfunction

  function automatic int led_at(int t);
    int p = t % PER;
    return ((p < BLW) && ((p % BLINK) < ON)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int cyc, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic t, input logic m);
    exp_t e;
    int   done;
    @(negedge clk);
    rst = r; d_start = s; d_stop = p; d_tick = t; d_mode = m;
    done = 0;
    if (r) begin
      m_run = 1'b0; m_t = 0; m_mode = 1'b0; m_total = 0;
    end else if (p) begin
      m_run = 1'b0; m_t = 0;
    end else if (!m_run) begin
      if (s) begin
        m_run = 1'b1; m_t = 0; m_mode = m;
      end
    end else if (t) begin
      m_total += blinks_at(m_t + 1) - blinks_at(m_t);
      done = (bursts_at(m_t + 1) > bursts_at(m_t)) ? 1 : 0;
      m_t++;
      if (m_mode && m_t == BLW) m_run = 1'b0;
    end
    e.cyc     = drv_cyc;
    e.led     = m_run ? led_at(m_t) : 0;
    e.busy    = m_run ? 1 : 0;
    e.done    = done;
    e.cnt     = (m_total > CMAX) ? CMAX : m_total;
    e.cnt_sat = (m_total > CMAX_S) ? CMAX_S : m_total;
    exp_q.push_back(e);
    if (done != 0) done_q.push_back(drv_cyc);
    drv_cyc++;
  endtask

  // Free-running cycles with a tick every 'period' clocks (period 0 = no ticks).
  task automatic run(input int n, input int period = 10);
    for (int i = 0; i < n; i++) begin
      logic t;
      t = (period > 0) && ((tick_phase % period) == period - 1);
      tick_phase++;
      step(1'b0, 1'b0, 1'b0, t, d_mode);
    end
  endtask

  task automatic start_run(input logic m);
    tick_phase = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, m);
  endtask

  task automatic stop_run();
    step(1'b0, 1'b0, 1'b1, 1'b0, d_mode);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led",           e.cyc, int'(bus_a.led),        e.led);
        check("busy",          e.cyc, int'(bus_a.busy),       e.busy);
        check("burst_done",    e.cyc, int'(bus_a.burst_done), e.done);
        check("blink_cnt",     e.cyc, int'(bus_a.blink_cnt),  e.cnt);
        check("blink_cnt_sat", e.cyc, int'(bus_b.blink_cnt),  e.cnt_sat);
        if (bus_a.burst_done) begin
          if (done_q.size() == 0) begin
            check("burst_event_unexpected", e.cyc, 1, 0);
          end else begin
            check("burst_event_cycle", e.cyc, e.cyc, done_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    int i;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(5);

    // Single burst, then repeat bursts with pause.
    start_run(1'b1);
    run(170);
    start_run(1'b0);
    run(420);

    // Stop during the second ON phase, then restart from blink 0.
    stop_run();
    run(5);
    start_run(1'b0);
    run(60);
    stop_run();
    run(20);
    start_run(1'b0);
    run(60);
    stop_run();

    // start+stop together, then a start pulse (with other mode) mid-burst.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(5);
    start_run(1'b0);
    run(30);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(200);
    stop_run();

    // Tick coincident with start is ignored; long idle stretch without ticks.
    tick_phase = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(1000, 0);
    run(50);
    stop_run();

    // Reset in the middle of an OFF phase.
    start_run(1'b0);
    run(35);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(20);

    // Back-to-back ticks.
    start_run(1'b1);
    run(40, 1);

    // Randomized traffic.
    for (i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", drv_cyc, exp_q.size(), 0);
    check("burst_events_left",  drv_cyc, done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
